// File: rtl/led_activity_pulse_gen_pkg.sv
// ============================================================================
// Module      : led_activity_pulse_gen_pkg
// Description : Shared constants for the LED activity pulse generator.
//               Holds the per-port FSM state encodings (2-bit) and the
//               hold-off / heartbeat counter width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_activity_pulse_gen_pkg;

    // Width of the hold-off and heartbeat counters.
    localparam int unsigned c_cnt_w = 32;

    // Per-port FSM state encodings.
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_pulse   = 2'd1;
    localparam logic [1:0] c_st_holdoff = 2'd2;

endpackage

`default_nettype wire

// File: rtl/led_activity_chan.sv
// ============================================================================
// Module      : led_activity_chan
// Description : Single-port frame-start detector with a hold-off window.
//               Emits a one-cycle activity pulse per detected frame start,
//               then suppresses further pulses for HOLDOFF_CYCLES cycles.
//               A start seen during the hold-off is remembered as a single
//               pending flag and released when the window closes.
// Ports       : i_clk          - system clock
//               i_rst_n        - asynchronous active-low reset
//               i_frame_valid  - frame-valid strobe, high for the whole frame
//               i_link_up      - link status, 1 = up
//               o_pulse        - registered one-cycle activity pulse
//               o_pulse_nxt    - next-state value of o_pulse (for OR-reduce)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_activity_chan
    import led_activity_pulse_gen_pkg::*;
#(
    parameter logic [31:0] HOLDOFF_CYCLES = 32'd125_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_valid,
    input  logic i_link_up,
    output logic o_pulse,
    output logic o_pulse_nxt
);

    localparam logic [c_cnt_w-1:0] c_holdoff_last = HOLDOFF_CYCLES - 32'd1;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_pend;
    logic               w_pend_nxt;
    logic               r_prev_valid;
    logic               r_armed;
    logic               r_pulse;
    logic               w_start;

    // r_armed stays low until valid has been sampled low once after reset,
    // so a frame already in progress at reset release is not counted.
    assign w_start = i_frame_valid & ~r_prev_valid & r_armed;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        if (!i_link_up) begin
            // Link loss overrides everything, including a pulse about to issue.
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        w_state_nxt = c_st_pulse;
                    end
                end
                c_st_pulse: begin
                    w_state_nxt = c_st_holdoff;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
                c_st_holdoff: begin
                    if (r_cnt == c_holdoff_last) begin
                        // A start landing on the last hold-off cycle counts too.
                        w_state_nxt = (r_pend | w_start) ? c_st_pulse : c_st_idle;
                        w_cnt_nxt   = '0;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                        if (w_start) begin
                            w_pend_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign o_pulse_nxt = (w_state_nxt == c_st_pulse);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_pend       <= 1'b0;
            r_prev_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pend       <= w_pend_nxt;
            r_prev_valid <= i_frame_valid;
            if (!i_frame_valid) begin
                r_armed <= 1'b1;
            end
            r_pulse      <= o_pulse_nxt;
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/led_activity_pulse_gen.sv
// ============================================================================
// Module      : led_activity_pulse_gen
// Description : Per-port frame-activity pulse generator feeding the LED
//               on-time stretchers. One led_activity_chan per port, a
//               registered OR of all pulses, and an optional heartbeat.
// Ports       : i_clk          - system clock
//               i_rst_n        - asynchronous active-low reset
//               iv_frame_valid - per-port frame-valid strobes
//               iv_link_up     - per-port link status, 1 = up
//               ov_pulse       - per-port one-cycle activity pulses
//               o_any_pulse    - OR of ov_pulse, cycle-aligned with it
//               o_heartbeat    - one-cycle pulse every HEARTBEAT_CYCLES
// Build option: LED_HEARTBEAT_EN - when defined, enables the free-running
//               heartbeat counter; otherwise o_heartbeat is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_activity_pulse_gen
    import led_activity_pulse_gen_pkg::*;
#(
    parameter int unsigned PORT_NUM         = 8,
    parameter logic [31:0] HOLDOFF_CYCLES   = 32'd125_000_000,
    parameter logic [31:0] HEARTBEAT_CYCLES = 32'd250_000_000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PORT_NUM-1:0] iv_frame_valid,
    input  logic [PORT_NUM-1:0] iv_link_up,
    output logic [PORT_NUM-1:0] ov_pulse,
    output logic                o_any_pulse,
    output logic                o_heartbeat
);

    logic [PORT_NUM-1:0] w_pulse_nxt;
    logic                r_any_pulse;

    genvar g;
    generate
        for (g = 0; g < PORT_NUM; g++) begin : g_chan
            led_activity_chan #(
                .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
            ) u_chan (
                .i_clk         (i_clk),
                .i_rst_n       (i_rst_n),
                .i_frame_valid (iv_frame_valid[g]),
                .i_link_up     (iv_link_up[g]),
                .o_pulse       (ov_pulse[g]),
                .o_pulse_nxt   (w_pulse_nxt[g])
            );
        end
    endgenerate

    // Registered from the next-state vector so it lines up with ov_pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_any_pulse <= 1'b0;
        end else begin
            r_any_pulse <= |w_pulse_nxt;
        end
    end

    assign o_any_pulse = r_any_pulse;

`ifdef LED_HEARTBEAT_EN
    localparam logic [c_cnt_w-1:0] c_hb_last = HEARTBEAT_CYCLES - 32'd1;

    logic [c_cnt_w-1:0] r_hb_cnt;
    logic               r_heartbeat;

    // First heartbeat lands HEARTBEAT_CYCLES cycles after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_heartbeat <= (r_hb_cnt == c_hb_last);
            if (r_hb_cnt == c_hb_last) begin
                r_hb_cnt <= '0;
            end else begin
                r_hb_cnt <= r_hb_cnt + 32'd1;
            end
        end
    end

    assign o_heartbeat = r_heartbeat;
`else
    // Constant zero; the parameter stays referenced so the interface is
    // identical in both builds.
    assign o_heartbeat = 1'b0 & (HEARTBEAT_CYCLES == 32'd0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_activity_pulse_gen.sv
// ============================================================================
// Module      : tb_led_activity_pulse_gen
// Description : Self-checking bench for led_activity_pulse_gen with
//               PORT_NUM=2, HOLDOFF_CYCLES=8, HEARTBEAT_CYCLES=16.
//               Expected pulses are queued per scenario and popped when the
//               corresponding cycle is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_activity_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] frame_valid;
    logic [1:0] link_up;
    logic [1:0] ov_pulse;
    logic       any_pulse;
    logic       heartbeat;

    typedef struct {
        int       cyc;
        logic [1:0] vec;
    } exp_t;

    exp_t sbq[$];
    int   hbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   base     = 0;

    led_activity_pulse_gen #(
        .PORT_NUM         (2),
        .HOLDOFF_CYCLES   (32'd8),
        .HEARTBEAT_CYCLES (32'd16)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .iv_frame_valid (frame_valid),
        .iv_link_up     (link_up),
        .ov_pulse       (ov_pulse),
        .o_any_pulse    (any_pulse),
        .o_heartbeat    (heartbeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reset pulse; returns at a negedge with rel cycle 0 (next edge = edge 1).
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
    endtask

    function automatic exp_t mk(int c, logic [1:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        return e;
    endfunction

    task automatic test_reset();
        frame_valid = 2'b00;
        link_up     = 2'b11;
        rst_n       = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ov_pulse !== 2'b00) begin
            failures++;
            $display("FAIL reset_pulse ov_pulse=%b expected=00", ov_pulse);
        end
        checks++;
        if (any_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_any any_pulse=%b expected=0", any_pulse);
        end
        checks++;
        if (heartbeat !== 1'b0) begin
            failures++;
            $display("FAIL reset_hb heartbeat=%b expected=0", heartbeat);
        end
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov_pulse !== 2'b00 || any_pulse !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle t=%0d ov_pulse=%b any=%b expected=00/0", t, ov_pulse, any_pulse);
            end
        end
    endtask

    task automatic test_single_frame();
        exp_t e;
        logic [1:0] expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
        sbq.push_back(mk(10, 2'b01));
        for (int t = 1; t <= 30; t++) begin
            frame_valid = {1'b0, (t >= 10 && t <= 14)};
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL single_frame t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL single_frame_left pending=%0d expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [1:0] expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
        sbq.push_back(mk(10, 2'b01));
        sbq.push_back(mk(19, 2'b01));  // pending release, 9 cycles later
        sbq.push_back(mk(30, 2'b01));
        for (int t = 1; t <= 45; t++) begin
            frame_valid = {1'b0, (t == 10 || t == 11 || t == 13 || t == 15 || t == 16 || t == 30 || t == 31)};
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL back_to_back t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL back_to_back_left pending=%0d expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_holdoff_end();
        exp_t e;
        logic [1:0] expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
        sbq.push_back(mk(10, 2'b01));
        sbq.push_back(mk(19, 2'b01));
        for (int t = 1; t <= 35; t++) begin
            frame_valid = {1'b0, (t == 10 || t == 11 || t == 19 || t == 20)};
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL holdoff_end t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL holdoff_end_left pending=%0d expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_link_drop();
        exp_t e;
        logic [1:0] expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
        sbq.push_back(mk(10, 2'b01));
        sbq.push_back(mk(26, 2'b01));  // first start after link returns
        for (int t = 1; t <= 40; t++) begin
            link_up     = {1'b1, !(t >= 15 && t <= 22)};
            frame_valid = {1'b0, (t == 10 || t == 11 || t == 13 || t == 17 || t == 18 || t == 26 || t == 27)};
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL link_drop t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL link_drop_left pending=%0d expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_simultaneous_reset();
        exp_t e;
        logic [1:0] expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
        sbq.push_back(mk(10, 2'b11));
        for (int t = 1; t <= 10; t++) begin
            frame_valid = (t >= 10) ? 2'b11 : 2'b00;
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL simultaneous t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        // Asynchronous reset while the pulse is being driven.
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov_pulse !== 2'b00 || any_pulse !== 1'b0 || heartbeat !== 1'b0) begin
            failures++;
            $display("FAIL async_reset ov_pulse=%b any=%b hb=%b expected=00/0/0", ov_pulse, any_pulse, heartbeat);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        // Valid still high at release: no pulse until it falls and rises.
        sbq.push_back(mk(33, 2'b11));
        for (int t = 1; t <= 45; t++) begin
            frame_valid = (t == 31 || t == 32) ? 2'b00 : 2'b11;
            @(posedge clk);
            @(negedge clk);
            expv = 2'b00;
            if (sbq.size() > 0 && sbq[0].cyc == t) begin
                e = sbq.pop_front();
                expv = e.vec;
            end
            checks++;
            if (ov_pulse !== expv || any_pulse !== (|expv)) begin
                failures++;
                $display("FAIL post_reset t=%0d ov_pulse=%b any=%b expected=%b/%b", t, ov_pulse, any_pulse, expv, |expv);
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL post_reset_left pending=%0d expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_heartbeat();
        logic expv;
        frame_valid = 2'b00;
        link_up     = 2'b11;
        do_reset();
`ifdef LED_HEARTBEAT_EN
        hbq.push_back(16);
        hbq.push_back(32);
        hbq.push_back(48);
`endif
        for (int t = 1; t <= 52; t++) begin
            @(posedge clk);
            @(negedge clk);
            expv = 1'b0;
            if (hbq.size() > 0 && hbq[0] == t) begin
                void'(hbq.pop_front());
                expv = 1'b1;
            end
            checks++;
            if (heartbeat !== expv) begin
                failures++;
                $display("FAIL heartbeat t=%0d heartbeat=%b expected=%b", t, heartbeat, expv);
            end
        end
        checks++;
        if (hbq.size() != 0) begin
            failures++;
            $display("FAIL heartbeat_left pending=%0d expected=0", hbq.size());
        end
        hbq.delete();
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_valid = 2'b00;
        link_up     = 2'b00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_holdoff_end();
        test_link_drop();
        test_simultaneous_reset();
        test_heartbeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_activity_pulse_gen.md
Name: led_activity_pulse_gen

Overview:
- Per-port frame-activity detector that feeds the LED on-time stretcher stages, one stretcher per port.
- Detects frame starts on per-port frame-valid strobes from the port MAC/datapath. Emits one-cycle activity pulses, rate-limited by a hold-off window.
- Under continuous traffic, each port's LED blinks at a visible period instead of staying solid.
- Sits between the port receive/transmit datapath and the LED drive logic.

Parameters:
- PORT_NUM, 8, number of monitored ports (1..32).
- HOLDOFF_CYCLES, 32'd125_000_000, minimum idle cycles after a pulse before the next pulse (≥1). Set ≥ the LED on-time so blinks are distinct.
- HEARTBEAT_CYCLES, 32'd250_000_000, heartbeat period; used only with LED_HEARTBEAT_EN (≥2).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- iv_frame_valid  input  PORT_NUM  per-port frame-valid; high for the duration of each frame.
- iv_link_up  input  PORT_NUM  per-port link status; 1 = link up.
- ov_pulse  output  PORT_NUM  per-port one-cycle activity pulse, active high; drives the stretcher's pulse input.
- o_any_pulse  output  1  registered OR of all ov_pulse bits, same cycle as ov_pulse.
- o_heartbeat  output  1  one-cycle heartbeat pulse (feature-dependent).

Behaviour:
- Reset values: ov_pulse=0, o_any_pulse=0, o_heartbeat=0. All internal state cleared: prev-valid registers=0, pending=0, counters=0, FSM=IDLE.
- Frame start, per port: start = iv_frame_valid & ~r_prev_valid, where r_prev_valid is the 1-cycle registered copy.
- Valid already high when reset deasserts: no start until it falls and rises again.
- Per-port FSM with three states:
  - IDLE: if start & link_up, go to PULSE.
  - PULSE: ov_pulse=1 for exactly this one cycle. Clear counter and pending; go to HOLDOFF.
  - HOLDOFF: counter increments each cycle. A start & link_up in this state sets pending. When counter == HOLDOFF_CYCLES-1, go to PULSE if pending (or a start in that same cycle), else IDLE.
- Latency: valid first sampled high at edge k gives ov_pulse high in the cycle after edge k (one register stage).
- Minimum pulse-to-pulse spacing is HOLDOFF_CYCLES+1 cycles.
- Multiple starts during HOLDOFF produce only one pulse; pending is a flag, not a count.
- Link down, any state, any cycle: return to IDLE next cycle. Clear pending and counter. ov_pulse forced to 0 in that same registered update, so no pulse is issued in the cycle after link drop.
- Starts with link down are ignored.
- Ports are fully independent. Simultaneous starts on several ports pulse in the same cycle.
- Counter is 32-bit and compares with equality only; it never wraps in normal operation.
- Illegal FSM encoding: recover to IDLE with ov_pulse=0.
- Asynchronous reset mid-operation clears everything immediately. Any pulse in flight is lost, with no glitch beyond reset.
- o_any_pulse is registered from the next-state pulse vector, so it aligns exactly with ov_pulse.

Optional Feature:
- Macro LED_HEARTBEAT_EN.
- Defined: a free-running 32-bit counter drives o_heartbeat=1 for one cycle every HEARTBEAT_CYCLES cycles.
  - The counter wraps from HEARTBEAT_CYCLES-1 to 0.
  - The first heartbeat occurs HEARTBEAT_CYCLES cycles after reset release.
  - It is independent of ports and links.
- Not defined: o_heartbeat tied to 0; no counter logic is synthesized. The port list is identical either way.

Decomposition:
- Shared package: FSM state encodings (IDLE/PULSE/HOLDOFF, 2-bit) and the counter-width constant (32).
- One sub-module, led_activity_chan: a single-port FSM, hold-off counter and edge detector, instantiated PORT_NUM times by generate.
- The top level holds the OR-reduction and the heartbeat counter.

Test Plan:
All scenarios use PORT_NUM=2, HOLDOFF_CYCLES=8, HEARTBEAT_CYCLES=16.
- Single frame: link_up=2'b11; port0 valid high 5 cycles from edge 10. Expect ov_pulse[0]=1 only in cycle 11, and o_any_pulse=1 in cycle 11. Port1 stays silent.
- Back-to-back frames: port0 frames start at edges 10, 13, 15 and 30. Expect pulses in cycles 11, 20 (pending) and 31. Spacing between the first two is 9 cycles.
- Start exactly at hold-off end: second start at edge 19 with no earlier pending. Expect pulse in cycle 20.
- Link drop: start at edge 10, pending set at 13, link0 drops at 15. Expect no pulse at 20. A start while the link is down is ignored. After link returns, the next start pulses with normal 1-cycle latency.
- Simultaneous ports, plus reset: both ports start at edge 10. Expect ov_pulse=2'b11 in cycle 11. Then assert reset during HOLDOFF: all outputs 0 immediately. A valid still high after reset release produces no pulse.
- Heartbeat, macro defined: o_heartbeat pulses at cycles 16, 32 and 48 after reset release. With the macro undefined, o_heartbeat stays 0 throughout.
